// File: rtl/dram_read_arbiter_pkg.sv
// Shared configuration for the DRAM read arbiter: default widths, depths and small helpers.
package dram_read_arbiter_pkg;

  localparam int unsigned GLOBAL_ADDR_BW    = 32;
  localparam int unsigned DATA_BW           = 32;
  localparam int unsigned CACHE_SIZE        = 4;
  localparam int unsigned DRAMARB_N_PORT    = 2;
  localparam int unsigned DRAMARB_TAG_DEPTH = 4;
  localparam int unsigned PERF_BW           = 16;

  typedef logic [$clog2(DRAMARB_N_PORT)-1:0] dram_tag_t;

  // Saturating increment for the performance counters.
  function automatic logic [PERF_BW-1:0] sat_inc(input logic [PERF_BW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dram_read_arbiter_rr_grant.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping around.
module dram_read_arbiter_rr_grant #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  localparam int unsigned CW = IW + 1;
  localparam logic [CW-1:0] NW = CW'(N);

  logic [CW-1:0] cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    cand     = '0;
    // Walk from the farthest offset down so the nearest requester is written last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, i_ptr} + CW'(i);
      if (cand >= NW) cand = cand - NW;
      if (i_req[cand[IW-1:0]]) begin
        o_any = 1'b1;
        o_idx = cand[IW-1:0];
      end
    end
    if (o_any) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/dram_read_arbiter.sv
// Merges N_PORT DRAM read-address streams into one request port and routes in-order read data back.
// Optional counters: define DRAM_ARB_PERF_EN to enable per-port grant/stall counters.
module dram_read_arbiter
  import dram_read_arbiter_pkg::*;
#(
  parameter int unsigned N_PORT    = DRAMARB_N_PORT,
  parameter int unsigned GBW       = GLOBAL_ADDR_BW,
  parameter int unsigned DBW       = DATA_BW,
  parameter int unsigned CSIZE     = CACHE_SIZE,
  parameter int unsigned TAG_DEPTH = DRAMARB_TAG_DEPTH
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [N_PORT-1:0]                 i_req_rdy,
  output logic [N_PORT-1:0]                 o_req_ack,
  input  logic [N_PORT-1:0][GBW-1:0]        i_req_addr,
  output logic                              o_dramra_rdy,
  input  logic                              i_dramra_ack,
  output logic [GBW-1:0]                    o_dramra,
  input  logic                              i_dramrd_rdy,
  output logic                              o_dramrd_ack,
  input  logic [CSIZE-1:0][DBW-1:0]         i_dramrd,
  output logic [N_PORT-1:0]                 o_rsp_rdy,
  input  logic [N_PORT-1:0]                 i_rsp_ack,
  output logic [CSIZE-1:0][DBW-1:0]         o_rsp_data,
  output logic [N_PORT-1:0][PERF_BW-1:0]    o_perf_grant,
  output logic [N_PORT-1:0][PERF_BW-1:0]    o_perf_stall
);

  localparam int unsigned TW   = $clog2(N_PORT);
  localparam int unsigned PW   = $clog2(TAG_DEPTH);
  localparam int unsigned CNTW = $clog2(TAG_DEPTH + 1);

  typedef logic [TW-1:0] tag_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  tag_t            rr_ptr_q, rr_ptr_d;
  logic            ra_vld_q, ra_vld_d;
  logic [GBW-1:0]  ra_addr_q, ra_addr_d;
  tag_t            tag_mem_q [TAG_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;

  logic [N_PORT-1:0] win_onehot;
  tag_t              win_idx;
  logic              win_any;
  logic              can_issue, grant, pop, tag_empty, tag_full;
  tag_t              tag_head;

  dram_read_arbiter_rr_grant #(
    .N (N_PORT)
  ) u_rr_grant (
    .i_req    (i_req_rdy),
    .i_ptr    (rr_ptr_q),
    .o_onehot (win_onehot),
    .o_idx    (win_idx),
    .o_any    (win_any)
  );

  assign tag_empty = (count_q == '0);
  // Full blocks grants regardless of a same-cycle pop, so the grant path never sees the return path.
  assign tag_full  = (count_q == CNTW'(TAG_DEPTH));
  assign can_issue = (!ra_vld_q || i_dramra_ack) && !tag_full;
  assign grant     = can_issue && win_any;
  assign o_req_ack = grant ? win_onehot : '0;

  assign o_dramra_rdy = ra_vld_q;
  assign o_dramra     = ra_addr_q;

  assign tag_head     = tag_mem_q[rd_ptr_q];
  assign o_dramrd_ack = !tag_empty && i_rsp_ack[tag_head];
  assign pop          = i_dramrd_rdy && o_dramrd_ack;
  assign o_rsp_data   = i_dramrd;

  always_comb begin
    o_rsp_rdy = '0;
    if (i_dramrd_rdy && !tag_empty) o_rsp_rdy[tag_head] = 1'b1;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    ra_vld_d  = ra_vld_q;
    ra_addr_d = ra_addr_q;
    if (grant) begin
      rr_ptr_d  = (win_idx == TW'(N_PORT - 1)) ? '0 : win_idx + 1'b1;
      ra_vld_d  = 1'b1;
      ra_addr_d = i_req_addr[win_idx];
    end else if (i_dramra_ack) begin
      ra_vld_d  = 1'b0;
    end
  end

  always_comb begin
    case ({grant, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rr_ptr_q  <= '0;
      ra_vld_q  <= 1'b0;
      ra_addr_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      ra_vld_q  <= ra_vld_d;
      ra_addr_q <= ra_addr_d;
      count_q   <= count_d;
      if (grant) begin
        tag_mem_q[wr_ptr_q] <= win_idx;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Read data must never arrive without an outstanding request to route it to.
  assert property (@(posedge i_clk) disable iff (!i_rst) i_dramrd_rdy |-> !tag_empty);

`ifdef DRAM_ARB_PERF_EN
  logic [N_PORT-1:0][PERF_BW-1:0] perf_grant_q, perf_grant_d;
  logic [N_PORT-1:0][PERF_BW-1:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_grant_d = perf_grant_q;
    perf_stall_d = perf_stall_q;
    for (int unsigned k = 0; k < N_PORT; k++) begin
      if (o_req_ack[k]) perf_grant_d[k] = sat_inc(perf_grant_q[k]);
      if (i_req_rdy[k] && !o_req_ack[k]) perf_stall_d[k] = sat_inc(perf_stall_q[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      perf_grant_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_grant_q <= perf_grant_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign o_perf_grant = perf_grant_q;
  assign o_perf_stall = perf_stall_q;
`else
  assign o_perf_grant = '0;
  assign o_perf_stall = '0;
`endif

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Randomized bench for dram_read_arbiter with a queue-based reference model and directed scenarios.
module tb_dram_read_arbiter;
  import dram_read_arbiter_pkg::*;

  localparam int unsigned N   = DRAMARB_N_PORT;
  localparam int unsigned GBW = GLOBAL_ADDR_BW;
  localparam int unsigned DBW = DATA_BW;
  localparam int unsigned CS  = CACHE_SIZE;
  localparam int unsigned TD  = DRAMARB_TAG_DEPTH;
  localparam int unsigned W   = 128;

  logic                          i_clk;
  logic                          i_rst;
  logic [N-1:0]                  i_req_rdy;
  logic [N-1:0]                  o_req_ack;
  logic [N-1:0][GBW-1:0]         i_req_addr;
  logic                          o_dramra_rdy;
  logic                          i_dramra_ack;
  logic [GBW-1:0]                o_dramra;
  logic                          i_dramrd_rdy;
  logic                          o_dramrd_ack;
  logic [CS-1:0][DBW-1:0]        i_dramrd;
  logic [N-1:0]                  o_rsp_rdy;
  logic [N-1:0]                  i_rsp_ack;
  logic [CS-1:0][DBW-1:0]        o_rsp_data;
  logic [N-1:0][PERF_BW-1:0]     o_perf_grant;
  logic [N-1:0][PERF_BW-1:0]     o_perf_stall;

  dram_read_arbiter u_dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_rdy    (i_req_rdy),
    .o_req_ack    (o_req_ack),
    .i_req_addr   (i_req_addr),
    .o_dramra_rdy (o_dramra_rdy),
    .i_dramra_ack (i_dramra_ack),
    .o_dramra     (o_dramra),
    .i_dramrd_rdy (i_dramrd_rdy),
    .o_dramrd_ack (o_dramrd_ack),
    .i_dramrd     (i_dramrd),
    .o_rsp_rdy    (o_rsp_rdy),
    .i_rsp_ack    (i_rsp_ack),
    .o_rsp_data   (o_rsp_data),
    .o_perf_grant (o_perf_grant),
    .o_perf_stall (o_perf_stall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0]     port;
    logic [GBW-1:0] addr;
  } ent_t;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model state: issued-but-unreturned requests in order, and the memory's accepted queue.
  ent_t           tq[$];
  logic [GBW-1:0] memq[$];
  bit             m_vld;
  logic [GBW-1:0] m_addr;
  int             m_ptr;
  int             m_pg[N];
  int             m_ps[N];
  logic [N-1:0]   hs_req;
  bit             hs_rd;
  int             grant_log[$];
  int             ret_log[$];

  int unsigned p_req, p_ra, p_rd, p_rsp;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  function automatic logic [CS-1:0][DBW-1:0] mk_data(input logic [GBW-1:0] a);
    logic [CS-1:0][DBW-1:0] d;
    for (int w = 0; w < CS; w++) d[w] = DBW'(a) ^ DBW'(32'h9E37_79B9 * (w + 1));
    return d;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Compare process: checks every cycle at the falling edge, then advances the model.
  initial begin : cmp
    int win, h, p;
    logic [N-1:0] e_ack, e_rsp;
    logic e_rdack, can;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        m_vld = 1'b0; m_addr = '0; m_ptr = 0; hs_req = '0; hs_rd = 1'b0;
        tq.delete(); memq.delete();
        for (int k = 0; k < N; k++) begin m_pg[k] = 0; m_ps[k] = 0; end
        chk("rst_req_ack", W'(o_req_ack), '0);
        chk("rst_dramra_rdy", W'(o_dramra_rdy), '0);
        chk("rst_dramra", W'(o_dramra), '0);
        chk("rst_rsp_rdy", W'(o_rsp_rdy), '0);
        chk("rst_dramrd_ack", W'(o_dramrd_ack), '0);
        chk("rst_perf", W'({o_perf_grant, o_perf_stall}), '0);
      end else begin
        can = (!m_vld || i_dramra_ack) && (tq.size() < TD);
        win = -1;
        if (can) begin
          for (int k = 0; k < N; k++) begin
            p = (m_ptr + k) % N;
            if (win < 0 && i_req_rdy[p]) win = p;
          end
        end
        e_ack = '0;
        if (win >= 0) e_ack[win] = 1'b1;
        e_rsp = '0; e_rdack = 1'b0; h = 0;
        if (tq.size() > 0) begin
          h = int'(tq[0].port);
          e_rdack = i_rsp_ack[h];
          if (i_dramrd_rdy) e_rsp[h] = 1'b1;
        end
        chk("req_ack", W'(o_req_ack), W'(e_ack));
        chk("dramra_rdy", W'(o_dramra_rdy), W'(m_vld));
        if (m_vld) chk("dramra", W'(o_dramra), W'(m_addr));
        chk("rsp_rdy", W'(o_rsp_rdy), W'(e_rsp));
        chk("dramrd_ack", W'(o_dramrd_ack), W'(e_rdack));
        for (int k = 0; k < N; k++) begin
          chk($sformatf("perf_grant%0d", k), W'(o_perf_grant[k]), W'(m_pg[k]));
          chk($sformatf("perf_stall%0d", k), W'(o_perf_stall[k]), W'(m_ps[k]));
        end
        if (o_req_ack != '0) grant_log.push_back(oh2idx(o_req_ack));
        if (i_dramrd_rdy && o_dramrd_ack) ret_log.push_back(oh2idx(o_rsp_rdy));

        hs_req = e_ack;
        if (m_vld && i_dramra_ack) memq.push_back(m_addr);
        hs_rd = i_dramrd_rdy && e_rdack;
        if (hs_rd) begin
          chk("rsp_data", W'(o_rsp_data), W'(mk_data(tq[0].addr)));
          void'(tq.pop_front());
          if (memq.size() > 0) void'(memq.pop_front());
        end
        if (win >= 0) begin
          tq.push_back('{port: 8'(win), addr: i_req_addr[win]});
          m_vld  = 1'b1;
          m_addr = i_req_addr[win];
          m_ptr  = (win + 1) % N;
        end else if (i_dramra_ack) begin
          m_vld = 1'b0;
        end
`ifdef DRAM_ARB_PERF_EN
        for (int k = 0; k < N; k++) begin
          if (e_ack[k]) begin
            if (m_pg[k] < 65535) m_pg[k]++;
          end else if (i_req_rdy[k]) begin
            if (m_ps[k] < 65535) m_ps[k]++;
          end
        end
`endif
      end
    end
  end

  // One cycle of protocol-legal stimulus, shaped by the p_* percentages.
  task automatic step();
    @(posedge i_clk); #1;
    for (int k = 0; k < N; k++) begin
      if (!i_req_rdy[k] || hs_req[k]) begin
        i_req_rdy[k]  = ($urandom_range(99) < p_req);
        i_req_addr[k] = GBW'($urandom());
      end
    end
    i_dramra_ack = ($urandom_range(99) < p_ra);
    if (i_dramrd_rdy && hs_rd) i_dramrd_rdy = 1'b0;
    if (!i_dramrd_rdy && memq.size() > 0 && $urandom_range(99) < p_rd) begin
      i_dramrd_rdy = 1'b1;
      i_dramrd     = mk_data(memq[0]);
    end
    for (int k = 0; k < N; k++) i_rsp_ack[k] = ($urandom_range(99) < p_rsp);
  endtask

  task automatic rst_assert();
    i_rst = 1'b0;
    i_req_rdy = '0; i_dramra_ack = 1'b0; i_dramrd_rdy = 1'b0; i_rsp_ack = '0;
    p_req = 0; p_ra = 0; p_rd = 0; p_rsp = 0;
  endtask

  task automatic rst_release();
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b1;
    grant_log.delete();
    ret_log.delete();
  endtask

  task automatic s1_single();
    p_req = 0; p_ra = 100; p_rd = 0; p_rsp = 100;
    step();
    i_req_rdy = 2'b01; i_req_addr[0] = 32'h100;
    @(negedge i_clk);
    chk("s1_ack", W'(o_req_ack), W'(2'b01));
    p_rd = 100;
    step();
    @(negedge i_clk);
    chk("s1_ra_rdy", W'(o_dramra_rdy), W'(1'b1));
    chk("s1_ra_addr", W'(o_dramra), W'(32'h100));
    step();
    @(negedge i_clk);
    chk("s1_ra_drop", W'(o_dramra_rdy), W'(1'b0));
    chk("s1_rsp_rdy", W'(o_rsp_rdy), W'(2'b01));
    chk("s1_rd_ack", W'(o_dramrd_ack), W'(1'b1));
    chk("s1_data", W'(o_rsp_data), W'(mk_data(32'h100)));
    step();
  endtask

  int exp_s, exp_g;

  initial begin : main
    i_req_rdy = '0; i_req_addr = '0; i_dramra_ack = 1'b0;
    i_dramrd_rdy = 1'b0; i_dramrd = '0; i_rsp_ack = '0;
    rst_assert();
    rst_release();

    // Single request and its return.
    s1_single();

    // Two ports requesting continuously alternate, and data comes back in the same order.
    rst_assert(); rst_release();
    p_req = 100; p_ra = 100; p_rd = 100; p_rsp = 100;
    repeat (12) step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s2_grant%0d", i), W'(i < grant_log.size() ? grant_log[i] : 9), W'(i % 2));
      chk($sformatf("s2_ret%0d", i), W'(i < ret_log.size() ? ret_log[i] : 9), W'(i % 2));
    end

    // Tag FIFO fills at four outstanding; a pop frees a slot only on the following cycle.
    rst_assert(); rst_release();
    p_req = 100; p_ra = 100; p_rd = 0; p_rsp = 100;
    repeat (8) step();
    chk("s3_grants", W'(grant_log.size()), W'(4));
    p_rd = 100;
    step();
    @(negedge i_clk);
    chk("s3_pop", W'(o_dramrd_ack), W'(1'b1));
    chk("s3_no_grant_in_pop", W'(o_req_ack), '0);
    p_rd = 0;
    step();
    @(negedge i_clk);
    chk("s3_grant_after_pop", W'(o_req_ack), W'(2'b01));
    step();
    @(negedge i_clk);
    chk("s3_full_again", W'(o_req_ack), '0);

    // Response back-pressure on port 1 holds the beat.
    rst_assert(); rst_release();
    p_req = 0; p_ra = 100; p_rd = 0; p_rsp = 0;
    step();
    i_req_rdy = 2'b10; i_req_addr[1] = 32'h200;
    p_rd = 100;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      @(negedge i_clk);
      chk("s4_hold_ack", W'(o_dramrd_ack), W'(1'b0));
      chk("s4_hold_rdy", W'(o_rsp_rdy), W'(2'b10));
    end
    p_rsp = 100;
    step();
    @(negedge i_clk);
    chk("s4_pop", W'(o_dramrd_ack), W'(1'b1));
    chk("s4_data", W'(o_rsp_data), W'(mk_data(32'h200)));
    p_rd = 0;
    step();

    // Reset with three outstanding and a pending request, then a fresh transaction.
    rst_assert(); rst_release();
    p_req = 100; p_ra = 100; p_rd = 0; p_rsp = 100;
    repeat (3) step();
    p_req = 0; p_ra = 0;
    step();
    @(negedge i_clk);
    chk("s5_pre_rdy", W'(o_dramra_rdy), W'(1'b1));
    #1 rst_assert();
    @(posedge i_clk); #1;
    chk("s5_rdy", W'(o_dramra_rdy), '0);
    chk("s5_addr", W'(o_dramra), '0);
    chk("s5_req_ack", W'(o_req_ack), '0);
    chk("s5_rsp_rdy", W'(o_rsp_rdy), '0);
    rst_release();
    s1_single();

    // Port 1 stalls five cycles behind a blocked issue register, then wins.
    rst_assert(); rst_release();
    p_req = 0; p_ra = 0; p_rd = 0; p_rsp = 0;
    step();
    i_req_rdy = 2'b01; i_req_addr[0] = 32'h300;
    step();
    i_req_rdy[1] = 1'b1; i_req_addr[1] = 32'h304;
    repeat (4) step();
    p_ra = 100;
    step();
    step();
    @(negedge i_clk);
`ifdef DRAM_ARB_PERF_EN
    exp_s = 5; exp_g = 1;
`else
    exp_s = 0; exp_g = 0;
`endif
    chk("s6_stall1", W'(o_perf_stall[1]), W'(exp_s));
    chk("s6_grant1", W'(o_perf_grant[1]), W'(exp_g));
    chk("s6_grant0", W'(o_perf_grant[0]), W'(exp_g));

    // Randomized traffic with a reset in the middle.
    rst_assert(); rst_release();
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) begin
        p_req = $urandom_range(100, 20); p_ra = $urandom_range(100, 20);
        p_rd  = $urandom_range(100, 20); p_rsp = $urandom_range(100, 20);
      end
      if (i == 1000) begin
        @(posedge i_clk); #1;
        rst_assert();
        rst_release();
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
